// File: rtl/axil_arbiter_2x1_pkg.sv
// Shared types for the two-requester AXI-Lite arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  typedef enum logic {
    OWN_S0 = 1'b0,
    OWN_S1 = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_S0) ? OWN_S1 : OWN_S0;
  endfunction

endpackage

// File: rtl/axil_arbiter_2x1_if.sv
// AXI-Lite bundle. clock/reset_n travel with the bundle but the arbiter
// runs from its own clock/reset ports.
interface axil_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input logic clock,
  input logic reset_n
);
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport main (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport peripheral (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arbiter_2x1_rr_arb2.sv
// Two-way round-robin arbiter: latches the winner on grant_en and hands
// priority to the loser once the owner's transaction is done.
module rr_arb2
  import axil_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  input  logic       done,
  output owner_t     winner
);
  owner_t ptr;
  owner_t pick;
  logic   ptr_req;

  // pointer holder wins if requesting, otherwise the other side
  always_comb begin
    ptr_req = (ptr == OWN_S0) ? req[0] : req[1];
    pick    = ptr_req ? ptr : other_owner(ptr);
  end

  // owner capture and pointer rotation
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr    <= OWN_S0;
      winner <= OWN_S0;
    end else begin
      if (grant_en) winner <= pick;
      if (done)     ptr    <= other_owner(winner);
    end
  end
endmodule

// File: rtl/axil_arbiter_2x1.sv
// Shares one AXI-Lite peripheral between two mains; read and write paths
// are arbitrated independently, one outstanding transaction per path.
module axil_arbiter_2x1
  import axil_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  axil_if.peripheral  s0,
  axil_if.peripheral  s1,
  axil_if.main        m
);
  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;
  owner_t  wown, rown;
  logic    aw_done, w_done, aw_done_nxt, w_done_nxt;
  logic    aw_hs, w_hs;
  logic [1:0] wreq, rreq;
  logic    wgrant, wfin, rgrant, rfin;

  logic [ADDRESS_WIDTH-1:0] o_awaddr, o_araddr;
  logic [2:0]               o_awprot, o_arprot;
  logic [DATA_WIDTH-1:0]    o_wdata;
  logic [DATA_WIDTH/8-1:0]  o_wstrb;
  logic                     o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;

  logic                     w_awready, w_wready, w_bvalid;
  logic [1:0]               w_bresp;
  logic                     r_arready, r_rvalid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [1:0]               r_rresp;

  assign wreq   = {s1.awvalid | s1.wvalid, s0.awvalid | s0.wvalid};
  assign rreq   = {s1.arvalid, s0.arvalid};
  assign wgrant = (wstate == W_IDLE) && (|wreq);
  assign rgrant = (rstate == R_IDLE) && (|rreq);
  assign wfin   = (wstate == W_RESP) && m.bvalid && o_bready;
  assign rfin   = (rstate == R_DATA) && m.rvalid && o_rready;

  rr_arb2 u_warb (
    .clock    (clock),
    .reset    (reset),
    .req      (wreq),
    .grant_en (wgrant),
    .done     (wfin),
    .winner   (wown)
  );

  rr_arb2 u_rarb (
    .clock    (clock),
    .reset    (reset),
    .req      (rreq),
    .grant_en (rgrant),
    .done     (rfin),
    .winner   (rown)
  );

  // request-side signals of whichever main owns each path
  always_comb begin
    o_awaddr  = (wown == OWN_S1) ? s1.awaddr  : s0.awaddr;
    o_awprot  = (wown == OWN_S1) ? s1.awprot  : s0.awprot;
    o_awvalid = (wown == OWN_S1) ? s1.awvalid : s0.awvalid;
    o_wdata   = (wown == OWN_S1) ? s1.wdata   : s0.wdata;
    o_wstrb   = (wown == OWN_S1) ? s1.wstrb   : s0.wstrb;
    o_wvalid  = (wown == OWN_S1) ? s1.wvalid  : s0.wvalid;
    o_bready  = (wown == OWN_S1) ? s1.bready  : s0.bready;
    o_araddr  = (rown == OWN_S1) ? s1.araddr  : s0.araddr;
    o_arprot  = (rown == OWN_S1) ? s1.arprot  : s0.arprot;
    o_arvalid = (rown == OWN_S1) ? s1.arvalid : s0.arvalid;
    o_rready  = (rown == OWN_S1) ? s1.rready  : s0.rready;
  end

  // write path: next state, done flags and owner<->m routing
  always_comb begin
    wstate_nxt  = wstate;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    m.awaddr    = '0;
    m.awprot    = '0;
    m.awvalid   = 1'b0;
    m.wdata     = '0;
    m.wstrb     = '0;
    m.wvalid    = 1'b0;
    m.bready    = 1'b0;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    w_bresp     = '0;
    unique case (wstate)
      W_IDLE: begin
        if (|wreq) wstate_nxt = W_ADDR;
      end
      W_ADDR: begin
        m.awaddr  = o_awaddr;
        m.awprot  = o_awprot;
        m.awvalid = o_awvalid & ~aw_done;
        m.wdata   = o_wdata;
        m.wstrb   = o_wstrb;
        m.wvalid  = o_wvalid & ~w_done;
        w_awready = m.awready & ~aw_done;
        w_wready  = m.wready & ~w_done;
        aw_hs     = o_awvalid & ~aw_done & m.awready;
        w_hs      = o_wvalid & ~w_done & m.wready;
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          wstate_nxt  = W_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end
      W_RESP: begin
        m.bready = o_bready;
        w_bvalid = m.bvalid;
        w_bresp  = m.bresp;
        if (m.bvalid && o_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // read path: next state and owner<->m routing
  always_comb begin
    rstate_nxt = rstate;
    m.araddr   = '0;
    m.arprot   = '0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    r_arready  = 1'b0;
    r_rvalid   = 1'b0;
    r_rdata    = '0;
    r_rresp    = '0;
    unique case (rstate)
      R_IDLE: begin
        if (|rreq) rstate_nxt = R_ADDR;
      end
      R_ADDR: begin
        m.araddr  = o_araddr;
        m.arprot  = o_arprot;
        m.arvalid = o_arvalid;
        r_arready = m.arready;
        if (o_arvalid && m.arready) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        m.rready = o_rready;
        r_rvalid = m.rvalid;
        r_rdata  = m.rdata;
        r_rresp  = m.rresp;
        if (m.rvalid && o_rready) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // response fan-out: the non-owner always sees zeros
  assign s0.awready = (wown == OWN_S0) & w_awready;
  assign s0.wready  = (wown == OWN_S0) & w_wready;
  assign s0.bvalid  = (wown == OWN_S0) & w_bvalid;
  assign s0.bresp   = (wown == OWN_S0) ? w_bresp : 2'b00;
  assign s1.awready = (wown == OWN_S1) & w_awready;
  assign s1.wready  = (wown == OWN_S1) & w_wready;
  assign s1.bvalid  = (wown == OWN_S1) & w_bvalid;
  assign s1.bresp   = (wown == OWN_S1) ? w_bresp : 2'b00;
  assign s0.arready = (rown == OWN_S0) & r_arready;
  assign s0.rvalid  = (rown == OWN_S0) & r_rvalid;
  assign s0.rdata   = (rown == OWN_S0) ? r_rdata : '0;
  assign s0.rresp   = (rown == OWN_S0) ? r_rresp : 2'b00;
  assign s1.arready = (rown == OWN_S1) & r_arready;
  assign s1.rvalid  = (rown == OWN_S1) & r_rvalid;
  assign s1.rdata   = (rown == OWN_S1) ? r_rdata : '0;
  assign s1.rresp   = (rown == OWN_S1) ? r_rresp : 2'b00;

  // state and done-flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wstate  <= W_IDLE;
      rstate  <= R_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      wstate  <= wstate_nxt;
      rstate  <= rstate_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Directed bench for axil_arbiter_2x1; the peripheral side is a zero-wait
// responder advanced inside step().
module tb_axil_arbiter_2x1;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic        aw_got = 1'b0, w_got = 1'b0;
  int          m_aw_cnt = 0, m_w_cnt = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          aw0, w0;

  always #5 clock = ~clock;

  axil_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) s0_if (.clock(clock), .reset_n(~reset));
  axil_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) s1_if (.clock(clock), .reset_n(~reset));
  axil_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) m_if  (.clock(clock), .reset_n(~reset));

  axil_arbiter_2x1 #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .s0    (s0_if),
    .s1    (s1_if),
    .m     (m_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_hs();
    return {17'd0,
            s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
            s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid,
            m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
  endfunction

  function automatic logic [31:0] s1_view();
    return {27'd0, s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid};
  endfunction

  // one clock: sample handshakes before the edge, update stimulus after it
  task automatic step();
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s;
    logic s0aw, s0w, s0ar, s1aw, s1w, s1ar;
    aw_hs = m_if.awvalid & m_if.awready;
    w_hs  = m_if.wvalid & m_if.wready;
    b_hs  = m_if.bvalid & m_if.bready;
    ar_hs = m_if.arvalid & m_if.arready;
    r_hs  = m_if.rvalid & m_if.rready;
    s0aw  = s0_if.awvalid & s0_if.awready;
    s0w   = s0_if.wvalid & s0_if.wready;
    s0ar  = s0_if.arvalid & s0_if.arready;
    s1aw  = s1_if.awvalid & s1_if.awready;
    s1w   = s1_if.wvalid & s1_if.wready;
    s1ar  = s1_if.arvalid & s1_if.arready;
    rst_s = reset;
    @(posedge clock);
    #1;
    if (s0aw) s0_if.awvalid = 1'b0;
    if (s0w)  s0_if.wvalid  = 1'b0;
    if (s0ar) s0_if.arvalid = 1'b0;
    if (s1aw) s1_if.awvalid = 1'b0;
    if (s1w)  s1_if.wvalid  = 1'b0;
    if (s1ar) s1_if.arvalid = 1'b0;
    if (rst_s) begin
      m_if.bvalid = 1'b0;
      m_if.rvalid = 1'b0;
      aw_got = 1'b0;
      w_got  = 1'b0;
    end else begin
      if (aw_hs) begin aw_got = 1'b1; m_aw_cnt++; end
      if (w_hs)  begin w_got  = 1'b1; m_w_cnt++;  end
      if (b_hs)  m_if.bvalid = 1'b0;
      if (aw_got && w_got) begin
        m_if.bvalid = 1'b1;
        m_if.bresp  = bresp_cfg;
        aw_got = 1'b0;
        w_got  = 1'b0;
      end
      if (r_hs) m_if.rvalid = 1'b0;
      if (ar_hs) begin
        m_if.rvalid = 1'b1;
        m_if.rdata  = rdata_cfg;
        m_if.rresp  = 2'b00;
      end
    end
    #1;
  endtask

  initial begin
    s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '0;
    s0_if.wvalid = 0; s0_if.bready = 1; s0_if.araddr = '0; s0_if.arprot = '0; s0_if.arvalid = 0;
    s0_if.rready = 1;
    s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '0;
    s1_if.wvalid = 0; s1_if.bready = 1; s1_if.araddr = '0; s1_if.arprot = '0; s1_if.arvalid = 0;
    s1_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.bresp = '0; m_if.bvalid = 0;
    m_if.arready = 1; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;

    step(); step();
    reset = 1'b0;
    #1;
    chk("reset_handshakes_zero", all_hs(), 32'd0);

    // single write from s0, zero-wait peripheral
    s0_if.awaddr = 32'h10; s0_if.awvalid = 1; s0_if.wdata = 32'hDEADBEEF;
    s0_if.wstrb = 4'hF; s0_if.wvalid = 1;
    #1;
    chk("wr_c1_no_awvalid", {31'd0, m_if.awvalid}, 32'd0);
    chk("wr_c1_no_awready", {31'd0, s0_if.awready}, 32'd0);
    step();
    chk("wr_c2_awvalid", {31'd0, m_if.awvalid}, 32'd1);
    chk("wr_c2_wvalid", {31'd0, m_if.wvalid}, 32'd1);
    chk("wr_c2_awaddr", m_if.awaddr, 32'h10);
    chk("wr_c2_wdata", m_if.wdata, 32'hDEADBEEF);
    chk("wr_c2_wstrb", {28'd0, m_if.wstrb}, 32'hF);
    chk("wr_c2_s0_awready", {31'd0, s0_if.awready}, 32'd1);
    chk("wr_c2_s1_quiet", s1_view(), 32'd0);
    step();
    chk("wr_c3_bvalid", {31'd0, s0_if.bvalid}, 32'd1);
    chk("wr_c3_bresp", {30'd0, s0_if.bresp}, 32'd0);
    chk("wr_c3_m_awvalid_low", {31'd0, m_if.awvalid}, 32'd0);
    chk("wr_c3_s1_quiet", s1_view(), 32'd0);
    step();
    chk("wr_c4_bvalid_low", {31'd0, s0_if.bvalid}, 32'd0);
    chk("wr_aw_count", m_aw_cnt, 32'd1);

    // read contention: s0 first, then s1
    rdata_cfg = 32'hA0;
    s0_if.araddr = 32'h40; s0_if.arvalid = 1;
    s1_if.araddr = 32'h44; s1_if.arvalid = 1;
    #1;
    step();
    chk("rd1_m_araddr_s0", m_if.araddr, 32'h40);
    chk("rd1_s0_arready", {31'd0, s0_if.arready}, 32'd1);
    chk("rd1_s1_arready_low", {31'd0, s1_if.arready}, 32'd0);
    step();
    chk("rd1_s0_rvalid", {31'd0, s0_if.rvalid}, 32'd1);
    chk("rd1_s0_rdata", s0_if.rdata, 32'hA0);
    chk("rd1_s1_not_yet", {31'd0, m_if.arvalid}, 32'd0);
    chk("rd1_s1_rvalid_low", {31'd0, s1_if.rvalid}, 32'd0);
    rdata_cfg = 32'hB1;
    step();
    chk("rd1_idle_no_arvalid", {31'd0, m_if.arvalid}, 32'd0);
    step();
    chk("rd2_m_araddr_s1", m_if.araddr, 32'h44);
    chk("rd2_s1_arready", {31'd0, s1_if.arready}, 32'd1);
    step();
    chk("rd2_s1_rdata", s1_if.rdata, 32'hB1);
    chk("rd2_s0_rvalid_low", {31'd0, s0_if.rvalid}, 32'd0);
    step();
    s0_if.araddr = 32'h48; s0_if.arvalid = 1;
    s1_if.araddr = 32'h4C; s1_if.arvalid = 1;
    #1;
    step();
    chk("rd3_alternate_s0", m_if.araddr, 32'h48);
    step(); step(); step();
    chk("rd4_alternate_s1", m_if.araddr, 32'h4C);
    step(); step();

    // split write from s1: w three cycles before aw, peripheral takes w first
    aw0 = m_aw_cnt; w0 = m_w_cnt;
    bresp_cfg = 2'b10;
    m_if.awready = 0; m_if.wready = 1;
    s1_if.wdata = 32'hCAFE0001; s1_if.wstrb = 4'h3; s1_if.wvalid = 1;
    #1;
    step();
    chk("split_c2_wvalid", {31'd0, m_if.wvalid}, 32'd1);
    chk("split_c2_awvalid_low", {31'd0, m_if.awvalid}, 32'd0);
    chk("split_c2_wdata", m_if.wdata, 32'hCAFE0001);
    step();
    chk("split_c3_wvalid_done", {31'd0, m_if.wvalid}, 32'd0);
    chk("split_c3_wready_masked", {31'd0, s1_if.wready}, 32'd0);
    step();
    s1_if.awaddr = 32'h30; s1_if.awvalid = 1;
    #1;
    chk("split_c4_awvalid", {31'd0, m_if.awvalid}, 32'd1);
    chk("split_c4_awaddr", m_if.awaddr, 32'h30);
    chk("split_c4_no_bvalid", {31'd0, s1_if.bvalid}, 32'd0);
    step();
    m_if.awready = 1;
    #1;
    chk("split_c5_awready", {31'd0, s1_if.awready}, 32'd1);
    step();
    chk("split_c6_bvalid", {31'd0, s1_if.bvalid}, 32'd1);
    chk("split_c6_bresp", {30'd0, s1_if.bresp}, 32'd2);
    chk("split_c6_s0_bvalid_low", {31'd0, s0_if.bvalid}, 32'd0);
    chk("split_one_aw", m_aw_cnt - aw0, 32'd1);
    chk("split_one_w", m_w_cnt - w0, 32'd1);
    step();
    chk("split_c7_bvalid_low", {31'd0, s1_if.bvalid}, 32'd0);

    // concurrent: s0 writes while s1 reads 0x20
    bresp_cfg = 2'b00;
    rdata_cfg = 32'h1234;
    s0_if.awaddr = 32'h50; s0_if.awvalid = 1; s0_if.wdata = 32'h55; s0_if.wstrb = 4'hF;
    s0_if.wvalid = 1;
    s1_if.araddr = 32'h20; s1_if.arvalid = 1;
    #1;
    step();
    chk("conc_m_awaddr", m_if.awaddr, 32'h50);
    chk("conc_m_araddr", m_if.araddr, 32'h20);
    chk("conc_both_valid", {30'd0, m_if.awvalid, m_if.arvalid}, 32'd3);
    step();
    chk("conc_s0_bvalid", {31'd0, s0_if.bvalid}, 32'd1);
    chk("conc_s1_rvalid", {31'd0, s1_if.rvalid}, 32'd1);
    chk("conc_s1_rdata", s1_if.rdata, 32'h1234);
    chk("conc_no_cross", {30'd0, s0_if.rvalid, s1_if.bvalid}, 32'd0);
    step();

    // backpressure: s0 holds rready low for 5 cycles, s1 ar pending
    rdata_cfg = 32'h7777;
    s0_if.rready = 0;
    s0_if.araddr = 32'h60; s0_if.arvalid = 1;
    #1;
    step(); step();
    s1_if.araddr = 32'h64; s1_if.arvalid = 1; s1_if.rready = 0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", {31'd0, s0_if.rvalid}, 32'd1);
      chk("bp_rdata", s0_if.rdata, 32'h7777);
      chk("bp_m_rready", {31'd0, m_if.rready}, 32'd0);
      chk("bp_s1_unserved", {30'd0, m_if.arvalid, s1_if.arready}, 32'd0);
      step();
    end
    s0_if.rready = 1;
    #1;
    step();
    step();
    chk("bp_then_s1_ar", m_if.araddr, 32'h64);
    step();
    chk("bp_s1_in_rdata", {31'd0, s1_if.rvalid}, 32'd1);

    // reset while s1 owns R_DATA with read pointer at s1
    reset = 1;
    rdata_cfg = 32'h9999;
    s0_if.araddr = 32'h70; s0_if.arvalid = 1; s0_if.rready = 1;
    s1_if.araddr = 32'h74; s1_if.arvalid = 1; s1_if.rready = 1;
    #1;
    step();
    chk("rst_mid_read_quiet", all_hs(), 32'd0);
    reset = 0;
    #1;
    step();
    chk("rst_ptr_s0_araddr", m_if.araddr, 32'h70);
    chk("rst_ptr_s0_arready", {30'd0, s0_if.arready, s1_if.arready}, 32'd2);
    step();
    chk("rst_new_read_rdata", s0_if.rdata, 32'h9999);
    chk("rst_new_read_rvalid", {31'd0, s0_if.rvalid}, 32'd1);
    step(); step(); step();
    chk("rst_s1_read_rdata", s1_if.rdata, 32'h9999);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
